jtag_tap_param: RTL and testbench

//  Parametrised IEEE 1149.1-style TAP controller: 16-state TAP FSM, IR_W-bit instruction register, and selectable data registers.

---
 rtl/jtag_tap_param.sv | 192 +++++++++++++++++++
 tb/tb_jtag_tap_param.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_param.sv
// IEEE 1149.1-style TAP controller with a parametrised instruction register and
// BYPASS / IDCODE / boundary-scan / USER data registers; tdo is the LSB of the active shift path.
module jtag_tap_param #(
    parameter int unsigned IR_W   = 4,
    parameter logic [31:0] IDCODE = 32'h1A5A_A001,
    parameter int unsigned BSR_W  = 8,
    parameter int unsigned USER_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tdi,
    input  logic              tms,
    output logic              tdo,
    output logic              tdo_en,
    output logic [3:0]        tap_state,
    output logic [IR_W-1:0]   ir_out,
    input  logic [BSR_W-1:0]  pins_in,
    output logic [BSR_W-1:0]  pins_out,
    output logic              extest,
    input  logic [USER_W-1:0] user_in,
    output logic [USER_W-1:0] user_out,
    output logic              user_upd
);

    typedef enum logic [3:0] {
        TLR   = 4'h0, RTI   = 4'h1, SELDR = 4'h2, CAPDR = 4'h3,
        SHDR  = 4'h4, EX1DR = 4'h5, PDR   = 4'h6, EX2DR = 4'h7,
        UPDR  = 4'h8, SELIR = 4'h9, CAPIR = 4'hA, SHIR  = 4'hB,
        EX1IR = 4'hC, PIR   = 4'hD, EX2IR = 4'hE, UPIR  = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_BSR    = 2'd2,
        DR_USER   = 2'd3
    } dr_sel_e;

    localparam logic [IR_W-1:0] OP_IDCODE = IR_W'(4'h1);
    localparam logic [IR_W-1:0] OP_SAMPLE = IR_W'(4'h2);
    localparam logic [IR_W-1:0] OP_EXTEST = IR_W'(4'h3);
    localparam logic [IR_W-1:0] OP_USER   = IR_W'(4'h4);
    localparam logic [IR_W-1:0] OP_BYPASS = {IR_W{1'b1}};

    tap_state_e        state_q, state_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic [IR_W-1:0]   ir_shift_q, ir_shift_d;
    logic [31:0]       idcode_dr_q, idcode_dr_d;
    logic [BSR_W-1:0]  bsr_q, bsr_d;
    logic [USER_W-1:0] user_dr_q, user_dr_d;
    logic              bypass_q, bypass_d;
    logic [BSR_W-1:0]  pins_out_q, pins_out_d;
    logic [USER_W-1:0] user_out_q, user_out_d;
    logic              user_upd_q, user_upd_d;
    dr_sel_e           dr_sel_s;

    // Instruction decode; unrecognised opcodes fall back to BYPASS
    always_comb begin
        dr_sel_s = DR_BYPASS;
        case (ir_q)
            OP_IDCODE:            dr_sel_s = DR_IDCODE;
            OP_SAMPLE, OP_EXTEST: dr_sel_s = DR_BSR;
            OP_USER:              dr_sel_s = DR_USER;
            OP_BYPASS:            dr_sel_s = DR_BYPASS;
            default:              dr_sel_s = DR_BYPASS;
        endcase
    end

    // TMS-driven state graph
    always_comb begin
        state_d = TLR;
        case (state_q)
            TLR:     state_d = tms ? TLR   : RTI;
            RTI:     state_d = tms ? SELDR : RTI;
            SELDR:   state_d = tms ? SELIR : CAPDR;
            CAPDR:   state_d = tms ? EX1DR : SHDR;
            SHDR:    state_d = tms ? EX1DR : SHDR;
            EX1DR:   state_d = tms ? UPDR  : PDR;
            PDR:     state_d = tms ? EX2DR : PDR;
            EX2DR:   state_d = tms ? UPDR  : SHDR;
            UPDR:    state_d = tms ? SELDR : RTI;
            SELIR:   state_d = tms ? TLR   : CAPIR;
            CAPIR:   state_d = tms ? EX1IR : SHIR;
            SHIR:    state_d = tms ? EX1IR : SHIR;
            EX1IR:   state_d = tms ? UPIR  : PIR;
            PIR:     state_d = tms ? EX2IR : PIR;
            EX2IR:   state_d = tms ? UPIR  : SHIR;
            UPIR:    state_d = tms ? SELDR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Register actions keyed off the current state; everything else holds
    always_comb begin
        ir_d        = ir_q;
        ir_shift_d  = ir_shift_q;
        idcode_dr_d = idcode_dr_q;
        bsr_d       = bsr_q;
        user_dr_d   = user_dr_q;
        bypass_d    = bypass_q;
        pins_out_d  = pins_out_q;
        user_out_d  = user_out_q;
        user_upd_d  = 1'b0;
        case (state_q)
            TLR:   ir_d       = OP_IDCODE;
            CAPIR: ir_shift_d = IR_W'(2'b01);
            SHIR:  ir_shift_d = (ir_shift_q >> 1) | (IR_W'(tdi) << (IR_W - 1));
            UPIR:  ir_d       = ir_shift_q;
            CAPDR: begin
                case (dr_sel_s)
                    DR_IDCODE: idcode_dr_d = IDCODE;
                    DR_BSR:    bsr_d       = pins_in;
                    DR_USER:   user_dr_d   = user_in;
                    default:   bypass_d    = 1'b0;
                endcase
            end
            SHDR: begin
                // tdi enters at the MSB so the register emerges LSB-first on tdo
                case (dr_sel_s)
                    DR_IDCODE: idcode_dr_d = (idcode_dr_q >> 1) | (32'(tdi) << 31);
                    DR_BSR:    bsr_d       = (bsr_q >> 1) | (BSR_W'(tdi) << (BSR_W - 1));
                    DR_USER:   user_dr_d   = (user_dr_q >> 1) | (USER_W'(tdi) << (USER_W - 1));
                    default:   bypass_d    = tdi;
                endcase
            end
            UPDR: begin
                case (dr_sel_s)
                    DR_BSR:  pins_out_d = bsr_q;
                    DR_USER: begin
                        user_out_d = user_dr_q;
                        user_upd_d = 1'b1;
                    end
                    default: user_upd_d = 1'b0;
                endcase
            end
            default: user_upd_d = 1'b0;
        endcase
    end

    // tdo presents the first bit as soon as a shift state is entered
    always_comb begin
        tdo = 1'b0;
        case (state_q)
            SHIR: tdo = ir_shift_q[0];
            SHDR: begin
                case (dr_sel_s)
                    DR_IDCODE: tdo = idcode_dr_q[0];
                    DR_BSR:    tdo = bsr_q[0];
                    DR_USER:   tdo = user_dr_q[0];
                    default:   tdo = bypass_q;
                endcase
            end
            default: tdo = 1'b0;
        endcase
    end

    // State and register file; TRST discards any partial scan and clears update latches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= TLR;
            ir_q        <= OP_IDCODE;
            ir_shift_q  <= {IR_W{1'b0}};
            idcode_dr_q <= 32'h0000_0000;
            bsr_q       <= {BSR_W{1'b0}};
            user_dr_q   <= {USER_W{1'b0}};
            bypass_q    <= 1'b0;
            pins_out_q  <= {BSR_W{1'b0}};
            user_out_q  <= {USER_W{1'b0}};
            user_upd_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            ir_shift_q  <= ir_shift_d;
            idcode_dr_q <= idcode_dr_d;
            bsr_q       <= bsr_d;
            user_dr_q   <= user_dr_d;
            bypass_q    <= bypass_d;
            pins_out_q  <= pins_out_d;
            user_out_q  <= user_out_d;
            user_upd_q  <= user_upd_d;
        end
    end

    assign tdo_en    = (state_q == SHIR) || (state_q == SHDR);
    assign tap_state = state_q;
    assign ir_out    = ir_q;
    assign extest    = (ir_q == OP_EXTEST);
    assign pins_out  = pins_out_q;
    assign user_out  = user_out_q;
    assign user_upd  = user_upd_q;

endmodule

// File: tb/tb_jtag_tap_param.sv
// Bench for jtag_tap_param: a queue-based TAP model predicts every tdo bit and output;
// a negedge monitor pops the expected tdo whenever tdo_en is high.
`timescale 1ns/1ps
module tb_jtag_tap_param;

    localparam int          IR_W   = 4;
    localparam logic [31:0] IDC    = 32'h1A5A_A001;
    localparam int          BSR_W  = 8;
    localparam int          USER_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              tdi = 1'b0;
    logic              tms = 1'b1;
    logic [BSR_W-1:0]  pins_in = '0;
    logic [USER_W-1:0] user_in = '0;
    logic              tdo, tdo_en, extest, user_upd;
    logic [3:0]        tap_state;
    logic [IR_W-1:0]   ir_out;
    logic [BSR_W-1:0]  pins_out;
    logic [USER_W-1:0] user_out;

    jtag_tap_param #(.IR_W(IR_W), .IDCODE(IDC), .BSR_W(BSR_W), .USER_W(USER_W)) dut (
        .clk(clk), .rst_n(rst_n), .tdi(tdi), .tms(tms), .tdo(tdo), .tdo_en(tdo_en),
        .tap_state(tap_state), .ir_out(ir_out), .pins_in(pins_in), .pins_out(pins_out),
        .extest(extest), .user_in(user_in), .user_out(user_out), .user_upd(user_upd)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit mon_on = 1'b0;

    // Next-state table of the 1149.1 graph: nxt[state][tms]
    int nxt [16][2] = '{
        '{1, 0},  '{1, 2},  '{3, 9},   '{4, 5},   '{4, 5},   '{6, 8},   '{6, 7},   '{4, 8},
        '{1, 2},  '{10, 0}, '{11, 12}, '{11, 12}, '{13, 15}, '{13, 14}, '{11, 15}, '{1, 2}
    };

    int                ms;
    logic [IR_W-1:0]   mir;
    logic [BSR_W-1:0]  mpins;
    logic [USER_W-1:0] muser;
    logic              mupd;
    logic              irq[$];
    logic              drq[$];
    logic              expq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sel_len(input logic [IR_W-1:0] op);
        case (op)
            4'h1:       return 32;
            4'h2, 4'h3: return BSR_W;
            4'h4:       return USER_W;
            default:    return 1;
        endcase
    endfunction

    function automatic logic [31:0] cap_val(input logic [IR_W-1:0] op);
        case (op)
            4'h1:       return IDC;
            4'h2, 4'h3: return 32'(pins_in);
            4'h4:       return 32'(user_in);
            default:    return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        ms = 0; mir = 4'h1; mpins = '0; muser = '0; mupd = 1'b0;
        irq.delete(); drq.delete(); expq.delete();
    endtask

    task automatic model_step(input logic t, input logic d);
        logic [31:0] v;
        int cur;
        cur  = ms;
        mupd = 1'b0;
        v    = 32'h0;
        case (cur)
            0:  mir = 4'h1;
            10: begin
                irq.delete();
                for (int i = 0; i < IR_W; i++) irq.push_back(logic'(i == 0));
            end
            11: begin void'(irq.pop_front()); irq.push_back(d); end
            15: begin foreach (irq[i]) v[i] = irq[i]; mir = v[IR_W-1:0]; end
            3: begin
                v = cap_val(mir);
                drq.delete();
                for (int i = 0; i < sel_len(mir); i++) drq.push_back(v[i]);
            end
            4:  begin void'(drq.pop_front()); drq.push_back(d); end
            8: begin
                foreach (drq[i]) v[i] = drq[i];
                if (mir == 4'h2 || mir == 4'h3) mpins = v[BSR_W-1:0];
                else if (mir == 4'h4) begin muser = v[USER_W-1:0]; mupd = 1'b1; end
            end
            default: ;
        endcase
        ms = nxt[cur][t];
        if (ms == 11) expq.push_back(irq[0]);
        else if (ms == 4) expq.push_back(drq[0]);
    endtask

    // Monitor: compare every output against the model, pop expected tdo while shifting
    always @(negedge clk) begin
        if (mon_on) begin
            chk("state", 32'(tap_state), 32'(ms));
            chk("ir_out", 32'(ir_out), 32'(mir));
            chk("pins_out", 32'(pins_out), 32'(mpins));
            chk("user_out", 32'(user_out), 32'(muser));
            chk("user_upd", 32'(user_upd), 32'(mupd));
            chk("extest", 32'(extest), 32'(mir == 4'h3));
            chk("tdo_en", 32'(tdo_en), 32'(ms == 4 || ms == 11));
            if (tdo_en) begin
                if (expq.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL tdo_underflow: tdo_en high with no expected bit at %0t", $time);
                end else begin
                    chk("tdo", 32'(tdo), 32'(expq.pop_front()));
                end
            end else begin
                chk("tdo_idle", 32'(tdo), 32'h0);
            end
        end
    end

    task automatic tick(input logic t, input logic d);
        @(negedge clk); #1;
        tms = t; tdi = d;
        model_step(t, d);
        @(posedge clk); #1;
    endtask

    task automatic ir_scan(input logic [IR_W-1:0] code, output logic [31:0] got);
        got = 32'h0;
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        for (int i = 0; i < IR_W; i++) begin
            got[i] = tdo;
            tick(logic'(i == IR_W - 1), code[i]);
        end
        tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    endtask

    task automatic dr_scan(input logic [31:0] val, input int n, input int pause_at,
                           output logic [31:0] got);
        logic last, brk;
        got = 32'h0;
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1);
            brk  = (i == pause_at) && !last;
            got[i] = tdo;
            tick(last || brk, val[i]);
            if (brk) begin
                tick(1'b0, 1'b1); tick(1'b0, 1'b1); tick(1'b1, 1'b0); tick(1'b0, 1'b0);
            end
        end
        tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk); #1;
        rst_n = 1'b0; tms = 1'b1;
        model_reset();
        #1;
        chk("rst_state", 32'(tap_state), 32'h0);
        chk("rst_ir", 32'(ir_out), 32'h1);
        chk("rst_pins", 32'(pins_out), 32'h0);
        chk("rst_user", 32'(user_out), 32'h0);
        chk("rst_tdo_en", 32'(tdo_en), 32'h0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        model_step(1'b1, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] got, rv;
        logic [IR_W-1:0] op;
        int len;
        logic [IR_W-1:0] ops [6];

        rst_n = 1'b1;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("por_state", 32'(tap_state), 32'h0);
        chk("por_tdo", 32'(tdo), 32'h0);
        mon_on = 1'b1;
        @(negedge clk); #1;
        rst_n = 1'b1; tms = 1'b0;
        model_step(1'b0, 1'b0);
        @(posedge clk); #1;
        chk("t1_state", 32'(tap_state), 32'h1);
        chk("t1_ir", 32'(ir_out), 32'h1);
        chk("t1_tdo", 32'(tdo), 32'h0);
        chk("t1_pins", 32'(pins_out), 32'h0);

        dr_scan(32'h0, 32, -1, got);
        chk("t2_idcode", got, 32'h1A5A_A001);

        ir_scan(4'hF, got);
        chk("t3_ir_capture", got, 32'h1);
        dr_scan(32'hD, 4, -1, got);
        chk("t3_bypass", got, 32'hA);

        pins_in = 8'h3C;
        ir_scan(4'h3, got);
        dr_scan(32'hA5, 8, -1, got);
        chk("t4_sample", got, 32'h3C);
        chk("t4_pins_out", 32'(pins_out), 32'hA5);
        chk("t4_extest", 32'(extest), 32'h1);

        user_in = 16'h1234;
        ir_scan(4'h4, got);
        dr_scan(32'hBEEF, 16, 7, got);
        chk("t5_capture", got, 32'h1234);
        chk("t5_user_out", 32'(user_out), 32'hBEEF);
        chk("t5_upd_hi", 32'(user_upd), 32'h1);
        tick(1'b0, 1'b0);
        chk("t5_upd_lo", 32'(user_upd), 32'h0);

        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        tick(1'b0, 1'b1); tick(1'b0, 1'b0); tick(1'b0, 1'b1);
        pulse_reset();
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0);
        chk("t6_pir", 32'(tap_state), 32'hD);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        chk("t6_tlr", 32'(tap_state), 32'h0);
        tick(1'b0, 1'b0);

        ops = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hF, 4'h0};
        for (int k = 0; k < 30; k++) begin
            op = ops[$urandom_range(0, 5)];
            if (op == 4'h0) op = IR_W'($urandom);
            pins_in = BSR_W'($urandom);
            user_in = USER_W'($urandom);
            ir_scan(op, got);
            len = sel_len(op);
            rv  = $urandom;
            dr_scan(rv, len, int'($urandom_range(0, len)), got);
            if (k % 5 == 4) begin
                for (int j = 0; j < 25; j++) tick(1'($urandom), 1'($urandom));
                for (int j = 0; j < 5; j++) tick(1'b1, 1'b0);
                tick(1'b0, 1'b0);
            end
        end

        @(negedge clk); #1;
        chk("sb_drain", 32'(expq.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
